// File: rtl/bcd_subtractor_seq.sv
// bcd_subtractor_seq
// Digit-serial packed-BCD subtractor: DIFF = A - B - bin, one digit per clock, LSD first.
// A start pulse captures the operands while idle. busy stays high for DIGITS cycles, then
// done pulses for one cycle. diff/bout/err are registered and held until the next completion.
// Any operand digit above 9 forces diff=0, bout=0, err=1 with unchanged latency.
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   start      request pulse, accepted only while idle
//   a, b       minuend / subtrahend, packed BCD, [3:0] = ones digit
//   bin        borrow-in
//   busy       operation in progress
//   done       one-cycle completion pulse
//   diff       BCD difference modulo 10^DIGITS
//   bout       borrow-out (A - B - bin < 0)
//   err        an operand digit was > 9
module bcd_subtractor_seq #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_a, w_a_next;
  logic [W-1:0]    r_b, w_b_next;
  logic            r_borrow, w_borrow_next;
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic [W-1:0]    r_part, w_part_next;
  logic            r_err_int, w_err_int_next;
  logic [W-1:0]    r_diff, w_diff_next;
  logic            r_bout, w_bout_next;
  logic            r_err, w_err_next;
  logic            r_done, w_done_next;

  logic [3:0]        w_a_dig, w_b_dig, w_digit;
  logic signed [4:0] w_t;
  logic              w_neg;
  logic [W-1:0]      w_part_wr;

  function automatic logic any_bad_digit(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Digit datapath: select digit r_idx, subtract with borrow, write back into partial result.
  always_comb begin
    w_a_dig   = 4'd0;
    w_b_dig   = 4'd0;
    w_part_wr = r_part;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
    // Range is -16..15, so 5-bit signed never overflows even for invalid digits.
    w_t     = $signed({1'b0, w_a_dig}) - $signed({1'b0, w_b_dig}) - $signed({4'b0, r_borrow});
    w_neg   = (w_t < 5'sd0);
    w_digit = w_neg ? 4'(w_t + 5'sd10) : w_t[3:0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IdxW'(i)) w_part_wr[4*i +: 4] = w_digit;
    end
  end

  // Next-state and register updates.
  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_b_next       = r_b;
    w_borrow_next  = r_borrow;
    w_idx_next     = r_idx;
    w_part_next    = r_part;
    w_err_int_next = r_err_int;
    w_diff_next    = r_diff;
    w_bout_next    = r_bout;
    w_err_next     = r_err;
    w_done_next    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_a_next       = a;
          w_b_next       = b;
          w_borrow_next  = bin;
          w_err_int_next = any_bad_digit(a, b);
          w_idx_next     = '0;
          w_part_next    = '0;
          w_state_next   = StCalc;
        end
      end
      StCalc: begin
        w_borrow_next = w_neg;
        w_part_next   = w_part_wr;
        if (r_idx == LastIdx) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
          w_diff_next  = r_err_int ? '0 : w_part_wr;
          w_bout_next  = r_err_int ? 1'b0 : w_neg;
          w_err_next   = r_err_int;
        end else begin
          w_idx_next = r_idx + IdxW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_borrow  <= 1'b0;
      r_idx     <= '0;
      r_part    <= '0;
      r_err_int <= 1'b0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_borrow  <= w_borrow_next;
      r_idx     <= w_idx_next;
      r_part    <= w_part_next;
      r_err_int <= w_err_int_next;
      r_diff    <= w_diff_next;
      r_bout    <= w_bout_next;
      r_err     <= w_err_next;
      r_done    <= w_done_next;
    end
  end

  assign busy = (r_state == StCalc);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
module tb_bcd_subtractor_seq;

  localparam int unsigned D = 3;
  localparam int unsigned W = 4 * D;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, bout, err;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  // Last completed result, i.e. what the outputs must hold until the next completion.
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  logic         last_err  = 1'b0;

  bcd_subtractor_seq #(.DIGITS(D)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference: decimal arithmetic on integer values, tens-complement wrap.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic me);
    int av, bv, wt, r;
    logic [3:0] na, nb;
    av = 0; bv = 0; wt = 1; me = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      na = ma[4*i +: 4];
      nb = mb[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) me = 1'b1;
      av += int'(na) * wt;
      bv += int'(nb) * wt;
      wt *= 10;
    end
    r   = av - bv - int'(mbin);
    mbo = (r < 0);
    if (r < 0) r += wt;
    md = '0;
    for (int i = 0; i < int'(D); i++) begin
      md[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (me) begin
      md  = '0;
      mbo = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < int'(D); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Called in cycle first_k after the capture edge. Observes only; returns latency in cycles
  // (-1 on timeout), busy cycle count, whether outputs held, and the outputs at done.
  task automatic wait_done(input int first_k, output int lat, output int bc, output bit hold,
                           output logic [W-1:0] od, output logic obo, output logic oe);
    lat = -1; bc = first_k - 1; hold = 1'b1;
    od = 'x; obo = 1'bx; oe = 1'bx;
    for (int k = first_k; k <= 20; k++) begin
      if (k > first_k) @(negedge clk);
      if (done === 1'b1) begin
        lat = k; od = diff; obo = bout; oe = err;
        break;
      end
      if (busy === 1'b1) bc++;
      if (diff !== last_diff || bout !== last_bout || err !== last_err) hold = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        output int lat, output int bc, output bit hold,
                        output logic [W-1:0] od, output logic obo, output logic oe);
    launch(ta, tb_v, tbin);
    wait_done(1, lat, bc, hold, od, obo, oe);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b err=%b, required all 0",
               busy, done, diff, bout, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Fixed vectors; expectations written as constants: a, b, bin, diff, bout, err.
  task automatic test_table(input string name, input int lo, input int hi);
    logic [W-1:0] va[7], vb[7], vd[7];
    logic         vbin[7], vbo[7], ve[7];
    int lat, bc;
    bit hold;
    logic [W-1:0] od;
    logic obo, oe;
    va = '{12'h532, 12'h100, 12'h000, 12'h999, 12'h123, 12'h1A5, 12'h050};
    vb = '{12'h278, 12'h001, 12'h001, 12'h999, 12'h000, 12'h010, 12'h020};
    vbin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vd = '{12'h254, 12'h099, 12'h999, 12'h999, 12'h122, 12'h000, 12'h030};
    vbo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ve  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = lo; i <= hi; i++) begin
      run_op(va[i], vb[i], vbin[i], lat, bc, hold, od, obo, oe);
      checks++;
      if (lat != int'(D) + 1 || bc != int'(D)) begin
        errors++;
        $display("FAIL %s_timing[%0d]: done at cycle %0d busy %0d cycles, required %0d and %0d",
                 name, i, lat, bc, D + 1, D);
      end
      checks++;
      if (!hold) begin
        errors++;
        $display("FAIL %s_hold[%0d]: outputs changed while busy, required held %h/%b/%b",
                 name, i, last_diff, last_bout, last_err);
      end
      checks++;
      if ({od, obo, oe} !== {vd[i], vbo[i], ve[i]}) begin
        errors++;
        $display("FAIL %s_result[%0d]: %h-%h-%b got diff=%h bout=%b err=%b, required %h %b %b",
                 name, i, va[i], vb[i], vbin[i], od, obo, oe, vd[i], vbo[i], ve[i]);
      end
      last_diff = vd[i]; last_bout = vbo[i]; last_err = ve[i];
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || {diff, bout, err} !== {vd[i], vbo[i], ve[i]}) begin
        errors++;
        $display("FAIL %s_pulse[%0d]: done=%b diff=%h after pulse, required done=0 diff=%h",
                 name, i, done, diff, vd[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit hold;
    logic [W-1:0] od;
    logic obo, oe;
    launch(12'h500, 12'h100, 1'b0);
    // cycle 1 now; drive a start during cycle 2 while busy
    @(negedge clk);
    a = 12'h900; b = 12'h800; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bc, hold, od, obo, oe);
    checks++;
    if (lat != int'(D) + 1 || {od, obo, oe} !== {12'h400, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d diff=%h bout=%b err=%b, required lat=%0d 400 0 0",
               lat, od, obo, oe, D + 1);
    end
    last_diff = 12'h400; last_bout = 1'b0; last_err = 1'b0;
    // still in the done cycle: start here must be accepted
    a = 12'h010; b = 12'h005; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, bc, hold, od, obo, oe);
    checks++;
    if (lat != int'(D) + 1 || bc != int'(D) || !hold) begin
      errors++;
      $display("FAIL done_cycle_start_timing: lat=%0d busy=%0d hold=%b, required %0d %0d 1",
               lat, bc, hold, D + 1, D);
    end
    checks++;
    if ({od, obo, oe} !== {12'h005, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL done_cycle_start: diff=%h bout=%b err=%b, required 005 0 0", od, obo, oe);
    end
    last_diff = 12'h005; last_bout = 1'b0; last_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, seen;
    bit hold;
    logic [W-1:0] od;
    logic obo, oe;
    launch(12'h777, 12'h111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, err} !== '0) begin
      errors++;
      $display("FAIL mid_op_reset: busy=%b done=%b diff=%h bout=%b err=%b, required all 0",
               busy, done, diff, bout, err);
    end
    rst_n = 1'b1;
    last_diff = '0; last_bout = 1'b0; last_err = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_op: done/busy active in %0d cycles after reset, required 0", seen);
    end
    run_op(12'h321, 12'h123, 1'b0, lat, bc, hold, od, obo, oe);
    checks++;
    if (lat != int'(D) + 1 || {od, obo, oe} !== {12'h198, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d diff=%h bout=%b err=%b, required %0d 198 0 0",
               lat, od, obo, oe, D + 1);
    end
    last_diff = 12'h198; last_bout = 1'b0; last_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int lat, bc;
    bit hold;
    logic [W-1:0] ra, rb, od, ed;
    logic rbin, obo, oe, ebo, ee;
    for (int i = 0; i < n; i++) begin
      ra = rand_bcd(1'b1);
      rb = rand_bcd(1'b1);
      rbin = 1'($urandom);
      model(ra, rb, rbin, ed, ebo, ee);
      run_op(ra, rb, rbin, lat, bc, hold, od, obo, oe);
      checks++;
      if (lat != int'(D) + 1 || bc != int'(D) || !hold) begin
        errors++;
        $display("FAIL rand_timing[%0d]: lat=%0d busy=%0d hold=%b, required %0d %0d 1",
                 i, lat, bc, hold, D + 1, D);
      end
      checks++;
      if ({od, obo, oe} !== {ed, ebo, ee}) begin
        errors++;
        $display("FAIL rand_result[%0d]: %h-%h-%b got %h %b %b, required %h %b %b",
                 i, ra, rb, rbin, od, obo, oe, ed, ebo, ee);
      end
      last_diff = ed; last_bout = ebo; last_err = ee;
    end
  endtask

  initial begin
    test_reset();
    test_table("arith", 0, 4);
    test_table("err", 5, 6);
    test_back_to_back();
    test_reset_mid_op();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
- Digit-serial BCD subtractor. Computes DIFF = A − B − bin over DIGITS packed BCD digits, one digit per clock, LSD first.
- It is the subtract-direction companion to the combinational BCD adder chain. It gives the display/calculator datapath 0–999 subtraction with a borrow chain.
- Uses a start/busy/done handshake so it can sit behind a keypad-entry FSM.
- Results are registered and held until the next accepted operation.

Parameters:
- DIGITS, 3, number of BCD digits per operand. Total latency is DIGITS+1 edges from start to done.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst_n  input  1  synchronous active-low reset, sampled on the sys_clk rising edge.
- start  input  1  request pulse. Accepted only when busy=0.
- a  input  4*DIGITS  minuend, packed BCD, a[3:0] = ones digit.
- b  input  4*DIGITS  subtrahend, packed BCD, same packing as a.
- bin  input  1  borrow-in (subtract one more).
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; diff, bout and err are valid from this cycle on.
- diff  output  4*DIGITS  BCD difference, modulo 10^DIGITS.
- bout  output  1  borrow-out. 1 when A − B − bin < 0.
- err  output  1  1 if any captured digit of a or b was > 9.

Behaviour:
- Reset (sys_rst_n=0 at a rising edge):
  - state → IDLE.
  - busy=0, done=0, diff=0, bout=0, err=0.
  - Internal operand, borrow and digit-index registers cleared.
  - Applies even mid-operation: the operation is aborted and no done is issued.
- State IDLE:
  - On an edge with start=1, capture a, b and bin into internal registers.
  - Evaluate err_int = OR over all captured digits of (digit > 9).
  - Clear the digit index and the partial result; state → CALC; busy=1 from the next cycle.
- State CALC, one digit per edge, index i from 0 to DIGITS−1:
  - t = a_i − b_i − borrow, computed at 5-bit signed width. borrow is initialised to bin.
  - If t < 0: digit_i = t + 10 and borrow = 1.
  - Otherwise: digit_i = t and borrow = 0.
  - digit_i is written into the partial result. Digits with indices ≥ i are not required to be correct until completion.
- Completion, on the edge that processes i = DIGITS−1:
  - state → IDLE; busy=0; done=1 for exactly one cycle.
  - diff ← partial result; bout ← final borrow; err ← err_int.
  - If err_int=1: diff ← 0 and bout ← 0. Latency is unchanged.
- Timing: start sampled at edge T → busy high for cycles T+1 .. T+DIGITS → done high in the cycle after edge T+DIGITS.
- Output hold: diff, bout and err change only at completion and are stable between operations, including while the next operation is busy.
- start while busy=1 is ignored; there is no queueing. Input operands are don't-care outside the capture edge.
- start=1 in the same cycle done=1 is accepted, because state is IDLE. Back-to-back throughput is one result per DIGITS+1 cycles.
- Invalid operand digits (A–F) never propagate: the result is forced to 0 with err=1.
- Underflow wraps to the tens-complement result, e.g. 000 − 001 → 999 with bout=1.

Test Plan (DIGITS=3):
- Reset, then a=0x532, b=0x278, bin=0, start pulse → busy high 3 cycles; done at cycle 4 with diff=0x254, bout=0, err=0.
- a=0x100, b=0x001, bin=0 → diff=0x099, bout=0. Then a=0x000, b=0x001 → diff=0x999, bout=1.
- a=0x999, b=0x999, bin=1 → diff=0x999, bout=1. Then a=0x123, b=0x000, bin=1 → diff=0x122, bout=0.
- a=0x1A5, b=0x010 → done after 4 cycles with err=1, diff=0x000, bout=0. A following valid op (0x050 − 0x020) clears err: diff=0x030.
- Start 0x500 − 0x100; pulse start with 0x900 − 0x800 at cycle 2 → ignored, result 0x400. Start issued in the done cycle with 0x010 − 0x005 → accepted, result 0x005.
- Start an op, assert sys_rst_n=0 at cycle 2 → busy=0, done never pulses, diff=0, bout=0, err=0. After release, a new op completes normally.
